vga_capture: RTL and testbench

VGA_CAPTURE -- requirements
Module: vga_capture

---
 rtl/vga_capture.sv | 115 +++++++++++
 tb/tb_vga_capture.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// vga_capture: recovers VGA timing from sampled syncs, locks on clean frames and writes a window to a frame buffer.
// Optional VGA_CAPTURE_TRANSPARENT_EN: in-window pixels equal to 8'hFF are not written.
module vga_capture #(
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int HPULSE  = 96,
    parameter int VPULSE  = 2,
    parameter int HBP     = 144,
    parameter int VBP     = 31,
    parameter int WIN_X   = 50,
    parameter int WIN_Y   = 40,
    parameter int WIN_W   = 256,
    parameter int WIN_H   = 256
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [1:0]  blue,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        locked,
    output logic        frame_done,
    output logic [7:0]  err_count,
    output logic [9:0]  cur_x,
    output logic [9:0]  cur_y
);
    localparam logic [9:0] HLAST = 10'(HPIXELS - 1);
    localparam logic [9:0] HPW   = 10'(HPULSE - 1);
    localparam logic [9:0] VLAST = 10'(VLINES - 1);
    localparam logic [9:0] VPW   = 10'(VPULSE - 1);
    localparam logic [9:0] X0    = 10'(HBP + WIN_X);
    localparam logic [9:0] X1    = 10'(HBP + WIN_X + WIN_W);
    localparam logic [9:0] Y0    = 10'(VBP + WIN_Y);
    localparam logic [9:0] Y1    = 10'(VBP + WIN_Y + WIN_H);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;
    state_t state, state_nx;
    logic hs_q, vs_q, hfall, hrise, vfall, vrise, viol, err_inc, wr_nx, fd_nx, key;
    logic [9:0] nx, ny;
    logic [7:0] dx, dy, pix;

    assign locked = state == LOCKED;

    // Checks use the previous sample's position, i.e. the position that just completed.
    always_comb begin
        hfall = pix_en & hs_q & ~hsync;
        hrise = pix_en & ~hs_q & hsync;
        vfall = pix_en & vs_q & ~vsync;
        vrise = pix_en & ~vs_q & vsync;
        nx = hfall ? 10'd0 : (&cur_x) ? cur_x : cur_x + 10'd1;
        ny = (hfall & vfall) ? 10'd0 : (hfall & ~&cur_y) ? cur_y + 10'd1 : cur_y;
        viol = (hfall & (cur_x != HLAST)) | (hrise & (cur_x != HPW)) |
               (vfall & (cur_y != VLAST)) | (vrise & (cur_y != VPW)) |
               (vfall & ~hfall) | (pix_en & ~hfall & (cur_x >= HLAST));
        dx = 8'(nx - X0);
        dy = 8'(ny - Y0);
        pix = {blue, green, red};
`ifdef VGA_CAPTURE_TRANSPARENT_EN
        key = pix == 8'hFF;
`else
        key = 1'b0;
`endif
        state_nx = state;
        err_inc = 1'b0;
        if (state != SEARCH && viol) begin
            state_nx = SEARCH;
            err_inc = 1'b1;
        end else if (state == SEARCH && vfall && hfall)
            state_nx = CHECK;
        else if (state == CHECK && vfall)
            state_nx = LOCKED;
        fd_nx = state == LOCKED && vfall && !viol;
        wr_nx = pix_en && state == LOCKED && !viol && !key &&
                nx >= X0 && nx < X1 && ny >= Y0 && ny < Y1;
    end

    always_ff @(posedge clk or posedge clr)
        if (clr)
            state <= SEARCH;
        else
            state <= state_nx;

    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            cur_x <= '0;
            cur_y <= '0;
            err_count <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_en <= wr_nx;
            frame_done <= fd_nx;
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (pix_en) begin
                hs_q <= hsync;
                vs_q <= vsync;
                cur_x <= nx;
                cur_y <= ny;
            end
            if (wr_nx) begin
                wr_addr <= {dx, dy};
                wr_data <= pix;
            end
        end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed frame-level bench on a scaled-down 40x24 timing with a 16x16 window at (10,5).
module tb_vga_capture;
    logic clk = 1'b0, clr = 1'b1, pix_en = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [2:0] red = '0, green = '0;
    logic [1:0] blue = '0;
    logic wr_en, locked, frame_done;
    logic [15:0] wr_addr;
    logic [7:0] wr_data, err_count;
    logic [9:0] cur_x, cur_y;

    vga_capture #(
        .HPIXELS(40), .VLINES(24), .HPULSE(4), .VPULSE(2), .HBP(8), .VBP(3),
        .WIN_X(2), .WIN_Y(2), .WIN_W(16), .WIN_H(16)
    ) dut (
        .clk(clk), .clr(clr), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .locked(locked), .frame_done(frame_done),
        .err_count(err_count), .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 clk = ~clk;

`ifdef VGA_CAPTURE_TRANSPARENT_EN
    localparam int TW = 255;
`else
    localparam int TW = 256;
`endif

    typedef struct {
        int gap; int bad; bit tr; bit won;
        bit e_lk0; bit e_fd0; bit e_lk; int e_err; int e_wr;
    } fvec_t;
    fvec_t tbl[7];

    int tests = 0, fails = 0, gap = 1, nwr = 0, nbad = 0;
    bit won = 1'b0;
    logic fd_s, lk_s, lk0, fd0, fd1;
    logic [15:0] first_addr, last_addr;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic smp(input logic hs, input logic vs, input logic [7:0] pix, input int col, input int line);
        logic ew;
        pix_en = 1'b1;
        hsync = hs;
        vsync = vs;
        {blue, green, red} = pix;
        @(posedge clk);
        #1;
        pix_en = 1'b0;
        fd_s = frame_done;
        lk_s = locked;
        ew = won && col >= 10 && col < 26 && line >= 5 && line < 21;
`ifdef VGA_CAPTURE_TRANSPARENT_EN
        if (pix == 8'hFF) ew = 1'b0;
`endif
        if (wr_en !== ew) nbad++;
        if (wr_en) begin
            if (wr_addr !== {8'(col - 10), 8'(line - 5)} || wr_data !== pix) nbad++;
            if (nwr == 0) first_addr = wr_addr;
            last_addr = wr_addr;
            nwr++;
        end
        for (int i = 1; i < gap; i++) begin
            @(posedge clk);
            #1;
            if (wr_en || frame_done) nbad++;
        end
    endtask

    task automatic frame(input int g, input int bad, input bit tr, input int sl, input int sc);
        gap = g;
        nwr = 0;
        nbad = 0;
        for (int l = 0; l < 24; l++)
            for (int c = 0; c < ((l == bad) ? 39 : 40); c++) begin
                smp(c >= 4, l >= 2, (tr && c == 15 && l == 10) ? 8'hFF : 8'(c - 10), c, l);
                if (l == 0 && c == 0) begin
                    lk0 = lk_s;
                    fd0 = fd_s;
                end
                if (l == 0 && c == 1) fd1 = fd_s;
                if (l == sl && c == sc) return;
            end
    endtask

    initial begin
        tbl[0] = '{4, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{4, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 256};
        tbl[2] = '{4, -1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 256};
        tbl[3] = '{2, 1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0};
        tbl[4] = '{2, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0};
        tbl[5] = '{2, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 256};
        tbl[6] = '{2, -1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, TW};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {wr_en, locked, frame_done, err_count, cur_x, cur_y, wr_addr, wr_data}, 64'd0);
        clr = 1'b0;

        for (int i = 0; i < 7; i++) begin
            won = tbl[i].won;
            frame(tbl[i].gap, tbl[i].bad, tbl[i].tr, -1, -1);
            chk($sformatf("f%0d_locked_at_vfall", i), lk0, tbl[i].e_lk0);
            chk($sformatf("f%0d_frame_done", i), fd0, tbl[i].e_fd0);
            chk($sformatf("f%0d_frame_done_width", i), fd1, 1'b0);
            chk($sformatf("f%0d_locked_end", i), locked, tbl[i].e_lk);
            chk($sformatf("f%0d_err_count", i), err_count, tbl[i].e_err);
            chk($sformatf("f%0d_writes", i), nwr, tbl[i].e_wr);
            chk($sformatf("f%0d_write_stream", i), nbad, 0);
            if (tbl[i].e_wr > 0) begin
                chk($sformatf("f%0d_first_addr", i), first_addr, 16'h0000);
                chk($sformatf("f%0d_last_addr", i), last_addr, 16'h0F0F);
            end
        end

        gap = 1;
        won = 1'b0;
        smp(1'b0, 1'b0, 8'h00, 0, 0);
        chk("stuck_frame_done", fd_s, 1'b1);
        for (int c = 1; c <= 70; c++) begin
            smp(c >= 4, 1'b0, 8'h00, c, 0);
            if (c == 39) begin
                chk("stuck_locked_before", locked, 1'b1);
                chk("stuck_cur_x_39", cur_x, 10'd39);
            end
            if (c == 40) begin
                chk("stuck_locked_after", locked, 1'b0);
                chk("stuck_err_at_40", err_count, 8'd2);
            end
        end
        chk("stuck_err_once", err_count, 8'd2);
        chk("stuck_cur_x_70", cur_x, 10'd70);
        for (int i = 0; i < 3; i++) smp(1'b1, 1'b1, 8'h00, 71 + i, 0);

        won = 1'b0;
        frame(1, -1, 1'b0, -1, -1);
        chk("relock_a_locked", lk0, 1'b0);
        chk("relock_a_writes", nwr, 0);
        won = 1'b1;
        frame(1, -1, 1'b0, -1, -1);
        chk("relock_b_locked", lk0, 1'b1);
        chk("relock_b_writes", nwr, 256);
        chk("relock_b_stream", nbad, 0);

        frame(1, -1, 1'b0, 12, 15);
        chk("mid_window_write", {wr_en, wr_addr}, {1'b1, 16'h0507});
        #2 clr = 1'b1;
        #1;
        chk("clr_async_outputs", {wr_en, locked, frame_done, err_count, cur_x, cur_y, wr_addr, wr_data}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("clr_held_wr_en", wr_en, 1'b0);
        clr = 1'b0;

        won = 1'b0;
        frame(1, -1, 1'b0, -1, -1);
        chk("post_clr_a_locked", lk0, 1'b0);
        chk("post_clr_a_writes", nwr, 0);
        chk("post_clr_a_stream", nbad, 0);
        won = 1'b1;
        frame(1, -1, 1'b0, -1, -1);
        chk("post_clr_b_locked", lk0, 1'b1);
        chk("post_clr_b_writes", nwr, 256);
        chk("post_clr_b_stream", nbad, 0);
        chk("post_clr_err", err_count, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
